// File: rtl/block_dispatcher_pkg.sv
// Shared types for the kernel block dispatcher: configuration record, block IDs
// and the dispatcher FSM state encoding.
package block_dispatcher_pkg;

  typedef logic [31:0] data_t;
  typedef data_t block_id_t;

  typedef struct packed {
    data_t num_blocks;
    data_t num_warps_per_block;
    data_t base_instr_addr;
    data_t base_data_addr;
  } kernel_config_t;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} dispatch_state_t;

endpackage

// File: rtl/block_dispatcher_picker.sv
// Combinational lowest-index selector over a free-core mask; reports whether
// any core is free plus the winner as one-hot and binary index.
module lowest_free_picker #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] free,
  output logic                 any,
  output logic [NUM_CORES-1:0] onehot,
  output logic [IDX_W-1:0]     index
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    any    = |free;
    onehot = '0;
    index  = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (free[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        index     = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/block_dispatcher.sv
// Kernel block dispatcher: latches a kernel configuration, launches block IDs
// onto free cores one per cycle and reports completion once all blocks retire.
module block_dispatcher
  import block_dispatcher_pkg::*;
#(
  parameter int NUM_CORES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  kernel_config_t       kernel_cfg,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_CORES-1:0] core_start,
  output block_id_t            core_block_id,
  output data_t                core_num_warps,
  output data_t                core_base_instr,
  output data_t                core_base_data,
  input  logic [NUM_CORES-1:0] core_done
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  dispatch_state_t      state;
  dispatch_state_t      state_next;
  kernel_config_t       cfg;
  data_t                dispatched;
  data_t                retired;
  data_t                retire_cnt;
  logic [NUM_CORES-1:0] core_busy;
  logic [NUM_CORES-1:0] core_busy_next;
  logic [NUM_CORES-1:0] free;
  logic [NUM_CORES-1:0] retire_mask;
  logic [NUM_CORES-1:0] pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic                 launch;
  logic                 accept;

  // Free mask uses registered occupancy, so a core retiring this cycle is only
  // eligible for a new block from the next cycle on.
  assign free = ~core_busy;

  lowest_free_picker #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_picker (
    .free   (free),
    .any    (pick_any),
    .onehot (pick_onehot),
    .index  (pick_idx)
  );

  always_comb begin
    retire_mask    = core_done & core_busy;
    retire_cnt     = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      retire_cnt = retire_cnt + data_t'(retire_mask[i]);
    end
    accept         = (state == IDLE) && start && !busy;
    launch         = (state == DISPATCH) && pick_any && (dispatched != cfg.num_blocks);
    core_busy_next = core_busy & ~retire_mask;
    if (launch) begin
      core_busy_next[pick_idx] = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = (kernel_cfg.num_blocks == '0) ? DONE : DISPATCH;
      DISPATCH: if (launch && (dispatched == cfg.num_blocks - 32'd1)) state_next = DRAIN;
      DRAIN:    if (retired == cfg.num_blocks) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // busy stays high through the cycle that shows the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      core_start    <= '0;
      core_block_id <= '0;
      cfg           <= '0;
      dispatched    <= '0;
      retired       <= '0;
      core_busy     <= '0;
    end else begin
      busy       <= (state_next != IDLE) || (state == DONE);
      done       <= (state == DONE);
      core_start <= launch ? pick_onehot : '0;
      core_busy  <= core_busy_next;
      if (launch) begin
        core_block_id <= dispatched;
      end
      if (accept) begin
        cfg        <= kernel_cfg;
        dispatched <= '0;
        retired    <= '0;
      end else begin
        if (launch) begin
          dispatched <= dispatched + 32'd1;
        end
        retired <= retired + retire_cnt;
      end
    end
  end

  assign core_num_warps  = cfg.num_warps_per_block;
  assign core_base_instr = cfg.base_instr_addr;
  assign core_base_data  = cfg.base_data_addr;

endmodule

// File: tb/tb_block_dispatcher.sv
// Scoreboard bench for block_dispatcher: directed kernels push expected launches
// and done events; a negedge monitor pops and compares them as the DUT emits.
module tb_block_dispatcher;
  import block_dispatcher_pkg::*;

  localparam int NUM_CORES = 4;

  typedef struct {
    bit          is_done;
    logic [3:0]  onehot;
    logic [31:0] id;
    logic [31:0] warps;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  kernel_config_t       kernel_cfg;
  logic                 busy;
  logic                 done;
  logic [NUM_CORES-1:0] core_start;
  block_id_t            core_block_id;
  data_t                core_num_warps;
  data_t                core_base_instr;
  data_t                core_base_data;
  logic [NUM_CORES-1:0] core_done;

  exp_t                 sb[$];
  logic [NUM_CORES-1:0] model_busy = '0;
  int                   checkCount = 0;
  int                   passCount  = 0;

  block_dispatcher #(.NUM_CORES(NUM_CORES)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .kernel_cfg      (kernel_cfg),
    .busy            (busy),
    .done            (done),
    .core_start      (core_start),
    .core_block_id   (core_block_id),
    .core_num_warps  (core_num_warps),
    .core_base_instr (core_base_instr),
    .core_base_data  (core_base_data),
    .core_done       (core_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) tick();
  endtask

  task automatic applyStimulus(input kernel_config_t cfg);
    kernel_cfg = cfg;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic retire(input logic [NUM_CORES-1:0] mask);
    core_done = mask;
    tick();
    core_done = '0;
  endtask

  task automatic pushLaunch(input logic [3:0] onehot, input logic [31:0] id, input logic [31:0] warps);
    exp_t e;
    e.is_done = 1'b0;
    e.onehot  = onehot;
    e.id      = id;
    e.warps   = warps;
    sb.push_back(e);
  endtask

  task automatic pushDone();
    exp_t e;
    e.is_done = 1'b1;
    e.onehot  = '0;
    e.id      = '0;
    e.warps   = '0;
    sb.push_back(e);
  endtask

  function automatic kernel_config_t mkCfg(input data_t nb, input data_t warps, input data_t instr, input data_t dat);
    kernel_config_t c;
    c.num_blocks          = nb;
    c.num_warps_per_block = warps;
    c.base_instr_addr     = instr;
    c.base_data_addr      = dat;
    return c;
  endfunction

  // Last retire sampled at edge M must show done after M+2, not M+1.
  task automatic checkDoneLatency(input string name);
    tick();
    checkOutput({name, " done early"}, 32'(done), 32'd0);
    tick();
    checkOutput({name, " done latency"}, 32'(done), 32'd1);
    waitCycles(2);
    checkOutput({name, " idle busy"}, 32'(busy), 32'd0);
    checkOutput({name, " scoreboard empty"}, 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("done order", 32'(e.is_done), 32'd1);
        checkOutput("busy during done", 32'(busy), 32'd1);
      end
    end
    if (!$isunknown(core_start) && core_start != '0) begin
      checkOutput("launch to idle core", 32'(core_start & model_busy), 32'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected launch", 32'(core_start), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("launch order", 32'(e.is_done), 32'd0);
        checkOutput("launch core", 32'(core_start), 32'(e.onehot));
        checkOutput("launch block id", core_block_id, e.id);
        checkOutput("launch warps", core_num_warps, e.warps);
      end
      model_busy = model_busy | core_start;
    end
    assert ((core_done & ~model_busy) == '0)
      else $error("[TB] core_done driven for a core with no block");
    model_busy = model_busy & ~core_done;
    if (reset) model_busy = '0;
  end

  initial begin
    int order [10];
    order = '{2, 0, 3, 1, 0, 2, 1, 3, 0, 2};
    reset      = 1'b1;
    start      = 1'b0;
    kernel_cfg = '0;
    core_done  = '0;
    waitCycles(3);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset core_start", 32'(core_start), 32'd0);
    checkOutput("reset block id", core_block_id, 32'd0);
    checkOutput("reset warps", core_num_warps, 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] two-block kernel");
    pushLaunch(4'b0001, 0, 4);
    pushLaunch(4'b0010, 1, 4);
    pushDone();
    applyStimulus(mkCfg(2, 4, 32'h1000, 32'h8000));
    checkOutput("busy after start", 32'(busy), 32'd1);
    waitCycles(3);
    checkOutput("base instr", core_base_instr, 32'h1000);
    checkOutput("base data", core_base_data, 32'h8000);
    retire(4'b0001);
    retire(4'b0010);
    checkDoneLatency("two-block");

    $display("[TB] ten-block kernel, staggered retires");
    pushLaunch(4'b0001, 0, 2);
    pushLaunch(4'b0010, 1, 2);
    pushLaunch(4'b0100, 2, 2);
    pushLaunch(4'b1000, 3, 2);
    pushLaunch(4'b0100, 4, 2);
    pushLaunch(4'b0001, 5, 2);
    pushLaunch(4'b1000, 6, 2);
    pushLaunch(4'b0010, 7, 2);
    pushLaunch(4'b0001, 8, 2);
    pushLaunch(4'b0100, 9, 2);
    pushDone();
    applyStimulus(mkCfg(10, 2, 32'h2000, 32'h9000));
    waitCycles(6);
    for (int i = 0; i < 9; i++) begin
      retire(4'(1 << order[i]));
      waitCycles(3);
    end
    retire(4'(1 << order[9]));
    checkDoneLatency("ten-block");

    $display("[TB] zero-block kernel");
    pushDone();
    applyStimulus(mkCfg(0, 5, 32'h0, 32'h0));
    checkOutput("zero busy", 32'(busy), 32'd1);
    checkOutput("zero done early", 32'(done), 32'd0);
    tick();
    checkOutput("zero done", 32'(done), 32'd1);
    waitCycles(2);
    checkOutput("zero idle busy", 32'(busy), 32'd0);
    checkOutput("zero scoreboard empty", 32'(sb.size()), 32'd0);

    $display("[TB] retire and launch in the same cycle");
    pushLaunch(4'b0001, 0, 3);
    pushLaunch(4'b0010, 1, 3);
    pushLaunch(4'b0100, 2, 3);
    pushLaunch(4'b1000, 3, 3);
    pushLaunch(4'b0001, 4, 3);
    pushLaunch(4'b0100, 5, 3);
    pushDone();
    applyStimulus(mkCfg(6, 3, 32'h3000, 32'hA000));
    waitCycles(5);
    retire(4'b0001);
    retire(4'b0100);
    checkOutput("same-cycle launch core", 32'(core_start), 32'b0001);
    tick();
    checkOutput("relaunch core 2", 32'(core_start), 32'b0100);
    waitCycles(2);
    retire(4'b0010);
    retire(4'b1000);
    retire(4'b0001);
    retire(4'b0100);
    checkDoneLatency("same-cycle");

    $display("[TB] reset during dispatch");
    pushLaunch(4'b0001, 0, 6);
    pushLaunch(4'b0010, 1, 6);
    pushLaunch(4'b0100, 2, 6);
    applyStimulus(mkCfg(8, 6, 32'h4000, 32'hB000));
    waitCycles(3);
    reset = 1'b1;
    tick();
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort core_start", 32'(core_start), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("abort no further launch", 32'(core_start), 32'd0);
    checkOutput("abort scoreboard empty", 32'(sb.size()), 32'd0);
    pushLaunch(4'b0001, 0, 3);
    pushDone();
    applyStimulus(mkCfg(1, 3, 32'h5000, 32'hC000));
    waitCycles(2);
    retire(4'b0001);
    checkDoneLatency("restart");

    $display("[TB] start while busy");
    pushLaunch(4'b0001, 0, 7);
    pushLaunch(4'b0010, 1, 7);
    pushDone();
    applyStimulus(mkCfg(2, 7, 32'h6000, 32'hD000));
    applyStimulus(mkCfg(5, 99, 32'h7000, 32'hE000));
    kernel_cfg = mkCfg(3, 55, 32'h0, 32'h0);
    waitCycles(3);
    checkOutput("warps held", core_num_warps, 32'd7);
    checkOutput("instr held", core_base_instr, 32'h6000);
    retire(4'b0001);
    retire(4'b0010);
    checkDoneLatency("start-while-busy");

    waitCycles(5);
    checkOutput("final scoreboard empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
